// File: rtl/cart_004_ctrl.sv
// MMC3-class mapper: CPU-written bank/control registers, PRG/CHR banking, RAM strobes, scanline IRQ.
// Address/strobe outputs are combinational; register writes land on the accepting edge; no backpressure.
module cart_004_ctrl #(
  parameter int PRG_ROM_DEPTH = 19,
  parameter int CHR_DEPTH     = 18,
  parameter int A12_FILTER    = 3
) (
  input  logic                     clk_cpu,
  input  logic                     rst,
  input  logic [14:0]              cpu_addr,
  input  logic [7:0]               cpu_data_i,
  input  logic                     cpu_rw,
  input  logic                     romsel,
  input  logic [13:0]              ppu_addr,
  output logic [PRG_ROM_DEPTH-1:0] prg_addr,
  output logic                     prg_ram_cs,
  output logic                     prg_ram_we,
  output logic [CHR_DEPTH-1:0]     chr_addr,
  output logic                     ciram_ce,
  output logic                     ciram_a10,
  output logic                     irq
);

  localparam int PB = PRG_ROM_DEPTH - 13;
  localparam int CB = CHR_DEPTH - 10;
  localparam int LW = (A12_FILTER < 1) ? 1 : $clog2(A12_FILTER + 1);
  localparam logic [LW-1:0] LOW_FULL     = LW'(A12_FILTER);
  localparam logic [PB-1:0] BANK_LAST    = '1;
  localparam logic [PB-1:0] BANK_LAST_M1 = {{(PB-1){1'b1}}, 1'b0};

  typedef enum logic [2:0] {
    REG_BANK_SEL   = 3'd0,
    REG_BANK_DATA  = 3'd1,
    REG_MIRROR     = 3'd2,
    REG_RAM_PROT   = 3'd3,
    REG_IRQ_LATCH  = 3'd4,
    REG_IRQ_RELOAD = 3'd5,
    REG_IRQ_DIS    = 3'd6,
    REG_IRQ_EN     = 3'd7
  } reg_sel_e;

  logic     wr_req;
  logic     wr_seen;
  logic     wr_hit;
  reg_sel_e reg_sel;

  // A write held for several cycles is accepted only on its first cycle.
  assign wr_req  = romsel & ~cpu_rw;
  assign wr_hit  = wr_req & ~wr_seen;
  assign reg_sel = reg_sel_e'({cpu_addr[14:13], cpu_addr[0]});

  always_ff @(posedge clk_cpu) begin
    if (rst) begin
      wr_seen <= 1'b0;
    end else begin
      wr_seen <= wr_req;
    end
  end

  logic [2:0]    bank_idx;
  logic          prg_mode;
  logic          chr_inv;
  logic [CB-1:0] chr_bank [0:5];
  logic [PB-1:0] prg_bank [0:1];
  logic          mirror_h;
  logic          ram_en;
  logic          ram_prot;

  always_ff @(posedge clk_cpu) begin
    if (rst) begin
      bank_idx    <= '0;
      prg_mode    <= 1'b0;
      chr_inv     <= 1'b0;
      for (int i = 0; i < 6; i++) begin
        chr_bank[i] <= '0;
      end
      prg_bank[0] <= '0;
      prg_bank[1] <= '0;
      mirror_h    <= 1'b0;
      ram_en      <= 1'b0;
      ram_prot    <= 1'b0;
    end else if (wr_hit) begin
      case (reg_sel)
        REG_BANK_SEL: begin
          bank_idx <= cpu_data_i[2:0];
          prg_mode <= cpu_data_i[6];
          chr_inv  <= cpu_data_i[7];
        end
        REG_BANK_DATA: begin
          // R6/R7 are PRG banks; R0..R5 are CHR banks.
          if (bank_idx[2:1] == 2'b11) begin
            prg_bank[bank_idx[0]] <= PB'(cpu_data_i);
          end else begin
            chr_bank[bank_idx] <= CB'(cpu_data_i);
          end
        end
        REG_MIRROR: begin
          mirror_h <= cpu_data_i[0];
        end
        REG_RAM_PROT: begin
          ram_en   <= cpu_data_i[7];
          ram_prot <= cpu_data_i[6];
        end
        default: ;
      endcase
    end
  end

  logic [PB-1:0] prg_bank_sel;

  always_comb begin
    prg_bank_sel = BANK_LAST;
    case (cpu_addr[14:13])
      2'b00:   prg_bank_sel = prg_mode ? BANK_LAST_M1 : prg_bank[0];
      2'b01:   prg_bank_sel = prg_bank[1];
      2'b10:   prg_bank_sel = prg_mode ? prg_bank[0] : BANK_LAST_M1;
      default: prg_bank_sel = BANK_LAST;
    endcase
  end

  assign prg_addr = {prg_bank_sel, cpu_addr[12:0]};

  logic          chr_a;
  logic [CB-1:0] chr_bank_sel;

  // Inversion swaps which pattern-table half gets the 2 KB pair banks.
  assign chr_a = ppu_addr[12] ^ chr_inv;

  always_comb begin
    chr_bank_sel = '0;
    if (chr_a) begin
      chr_bank_sel = chr_bank[3'd2 + {1'b0, ppu_addr[11:10]}];
    end else begin
      chr_bank_sel = {chr_bank[{2'b00, ppu_addr[11]}][CB-1:1], ppu_addr[10]};
    end
  end

  assign chr_addr   = {chr_bank_sel, ppu_addr[9:0]};
  assign ciram_ce   = ppu_addr[13];
  assign ciram_a10  = mirror_h ? ppu_addr[11] : ppu_addr[10];
  assign prg_ram_cs = ~romsel & (cpu_addr[14:13] == 2'b11) & ram_en;
  assign prg_ram_we = prg_ram_cs & ~cpu_rw & ~ram_prot;

  logic          a12_q;
  logic          a12_prev;
  logic          a12_rise;
  logic [LW-1:0] lowcnt;

  always_ff @(posedge clk_cpu) begin
    if (rst) begin
      a12_q    <= 1'b0;
      a12_prev <= 1'b0;
      lowcnt   <= '0;
    end else begin
      a12_q    <= ppu_addr[12];
      a12_prev <= a12_q;
      if (a12_q) begin
        lowcnt <= '0;
      end else if (lowcnt != LOW_FULL) begin
        lowcnt <= lowcnt + LW'(1);
      end
    end
  end

  // Only a rise preceded by a full run of low samples clocks the scanline counter.
  assign a12_rise = a12_q & ~a12_prev & (lowcnt == LOW_FULL);

  logic [7:0] irq_latch;
  logic [7:0] irq_cnt;
  logic [7:0] cnt_step;
  logic       irq_reload;
  logic       irq_en;

  assign cnt_step = ((irq_cnt == 8'd0) || irq_reload) ? irq_latch : irq_cnt - 8'd1;

  always_ff @(posedge clk_cpu) begin
    if (rst) begin
      irq_latch  <= 8'd0;
      irq_cnt    <= 8'd0;
      irq_reload <= 1'b0;
      irq_en     <= 1'b0;
      irq        <= 1'b0;
    end else begin
      if (wr_hit && reg_sel == REG_IRQ_LATCH) begin
        irq_latch <= cpu_data_i;
      end
      // A reload write takes priority and swallows a coincident edge.
      if (wr_hit && reg_sel == REG_IRQ_RELOAD) begin
        irq_cnt    <= 8'd0;
        irq_reload <= 1'b1;
      end else if (a12_rise) begin
        irq_cnt    <= cnt_step;
        irq_reload <= 1'b0;
        if (cnt_step == 8'd0 && irq_en) begin
          irq <= 1'b1;
        end
      end
      if (wr_hit && reg_sel == REG_IRQ_DIS) begin
        irq_en <= 1'b0;
        irq    <= 1'b0;
      end else if (wr_hit && reg_sel == REG_IRQ_EN) begin
        irq_en <= 1'b1;
      end
    end
  end

endmodule
